// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch types: instruction length, buffer entry, B-immediate decode.
package fetch_pkg;

    localparam int ILEN   = 32;
    localparam int PC_MAX = 32;

    // Buffer entries carry the widest legal PC; narrower configurations zero-extend.
    typedef struct packed {
        logic [PC_MAX-1:0] pc;
        logic [ILEN-1:0]   instr;
    } fetch_entry_t;

    function automatic logic [31:0] b_imm(input logic [ILEN-1:0] instr);
        return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - power-of-two instruction buffer with push/pop/flush and occupancy count.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // The producer never pushes into a full buffer unless a pop frees a slot in the same cycle.
    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign valid   = (count != '0);

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - sequential instruction fetch with branch redirect and a small buffer.
// Optional misaligned-target trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
    parameter int                  PC_WIDTH     = 12,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int                  DEPTH        = 2
) (
    input  logic                clk,
    input  logic                rst,
    output logic [PC_WIDTH-1:0] imem_addr,
    output logic                imem_req,
    input  logic [31:0]         imem_rdata,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    input  logic [31:0]         redirect_instr,
    output logic                inst_valid,
    input  logic                inst_ready,
    output logic [31:0]         inst_data,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic                misalign_err,
`endif
    output logic [PC_WIDTH-1:0] inst_pc
);

    import fetch_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] inflight_pc;
    logic [PC_WIDTH-1:0] target;
    logic [31:0]         target_full;
    logic                inflight;
    logic                halted;
    logic                req;
    logic                push;
    logic                pop;
    logic                flush;
    logic                fifo_valid;
    logic [CW-1:0]       fifo_count;
    logic [CW:0]         occupancy;
    fetch_entry_t        wr_entry;
    fetch_entry_t        rd_entry;
    logic                unused_bits;

    assign target_full = 32'(redirect_pc) + b_imm(redirect_instr);

`ifdef FETCH_MISALIGN_TRAP_EN
    assign target = target_full[PC_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            halted <= 1'b0;
        end else if (redirect_valid) begin
            halted <= target[1];
        end
    end

    assign misalign_err = halted;
`else
    assign target = {target_full[PC_WIDTH-1:2], 1'b0, target_full[0]};
    assign halted = 1'b0;
`endif

    // A handshake in the reset cycle is suppressed; in a redirect cycle it still retires the head.
    assign pop       = fifo_valid & inst_ready & ~rst;
    assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
    assign req       = ~rst & ~redirect_valid & ~halted & (occupancy < (CW+1)'(DEPTH));
    assign push      = inflight & ~redirect_valid & ~rst;
    assign flush     = rst | redirect_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_VECTOR;
            inflight    <= 1'b0;
            inflight_pc <= RESET_VECTOR;
        end else begin
            inflight <= req;
            if (req) begin
                inflight_pc <= pc;
            end
            if (redirect_valid) begin
                pc <= target;
            end else if (req) begin
                pc <= pc + PC_WIDTH'(4);
            end
        end
    end

    always_comb begin
        wr_entry       = '0;
        wr_entry.pc    = PC_MAX'(inflight_pc);
        wr_entry.instr = imem_rdata;
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk     (clk),
        .flush   (flush),
        .push    (push),
        .wr_data (wr_entry),
        .pop     (pop),
        .rd_data (rd_entry),
        .valid   (fifo_valid),
        .count   (fifo_count)
    );

    assign imem_addr  = pc;
    assign imem_req   = req;
    assign inst_valid = fifo_valid & ~rst;
    assign inst_data  = rd_entry.instr;
    assign inst_pc    = rd_entry.pc[PC_WIDTH-1:0];

    assign unused_bits = ^{target_full, redirect_instr, rd_entry.pc};

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed plus random checks of fetch_unit against a queue-based fetch model.
module tb_fetch_unit;

    localparam int          DEPTH = 2;
    localparam logic [11:0] RV    = 12'h100;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [11:0] redirect_pc;
    logic [31:0] redirect_instr;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [11:0] inst_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign_err;
`endif

    fetch_unit #(
        .PC_WIDTH     (12),
        .RESET_VECTOR (RV),
        .DEPTH        (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_req       (imem_req),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_instr (redirect_instr),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
`ifdef FETCH_MISALIGN_TRAP_EN
        .misalign_err   (misalign_err),
`endif
        .inst_pc        (inst_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [11:0] a);
        return 32'hC0DE_0000 ^ ({20'd0, a} * 32'd40503);
    endfunction

    // Memory answers one cycle after a request; garbage otherwise.
    always @(posedge clk) begin
        imem_rdata <= imem_req ? mem_word(imem_addr) : $urandom;
    end

    function automatic logic [31:0] enc_b(input int off);
        logic [12:0] imm;
        logic [12:0] fill;
        imm  = off[12:0];
        fill = 13'($urandom);
        return {imm[12], imm[10:5], fill, imm[4:1], imm[11], 7'b1100011};
    endfunction

    typedef struct {
        logic [11:0] pc;
        int          cyc;
    } pend_t;

    pend_t       q[$];
    logic [11:0] fetch_pc = RV;
    bit          m_halt   = 1'b0;
    int          cyc      = 0;
    int          total    = 0;
    int          bad      = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic cycle(input bit r, input bit rdy, input bit rv, input logic [11:0] rpc, input int off);
        bit          exp_valid;
        bit          exp_req;
        bit          pop;
        logic [11:0] tgt;
        rst            = r;
        inst_ready     = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        redirect_instr = enc_b(off);
        @(negedge clk);
        exp_valid = !r && (q.size() > 0) && (cyc - q[0].cyc >= 2);
        chk("inst_valid", inst_valid, exp_valid);
        if (exp_valid) begin
            chk("inst_pc", inst_pc, q[0].pc);
            chk("inst_data", inst_data, mem_word(q[0].pc));
        end
        pop     = exp_valid && rdy;
        exp_req = !r && !rv && !m_halt && ((q.size() - int'(pop)) < DEPTH);
        chk("imem_req", imem_req, exp_req);
        if (exp_req) begin
            chk("imem_addr", imem_addr, fetch_pc);
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("misalign_err", misalign_err, m_halt);
`endif
        if (pop) begin
            void'(q.pop_front());
        end
        if (r) begin
            q.delete();
            fetch_pc = RV;
            m_halt   = 1'b0;
        end else if (rv) begin
            q.delete();
            tgt = 12'((int'(rpc) + off) & 32'hFFF);
`ifdef FETCH_MISALIGN_TRAP_EN
            m_halt = tgt[1];
`else
            tgt[1] = 1'b0;
`endif
            fetch_pc = tgt;
        end else if (exp_req) begin
            q.push_back('{pc: fetch_pc, cyc: cyc});
            fetch_pc = fetch_pc + 12'd4;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit          r;
        bit          rv;
        bit          rdy;
        logic [11:0] rpc;
        int          off;
        rst            = 1'b1;
        inst_ready     = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        redirect_instr = '0;
        repeat (2) @(posedge clk);
        #1;

        repeat (2) cycle(1, 1, 0, 12'h000, 0);
        repeat (6) cycle(0, 1, 0, 12'h000, 0);
        repeat (5) cycle(0, 0, 0, 12'h000, 0);
        repeat (4) cycle(0, 1, 0, 12'h000, 0);
        repeat (2) cycle(0, 0, 0, 12'h000, 0);
        cycle(0, 1, 1, 12'h040, -8);
        repeat (6) cycle(0, 1, 0, 12'h000, 0);
        cycle(0, 1, 1, 12'hFF0, 0);
        repeat (8) cycle(0, 1, 0, 12'h000, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
        cycle(0, 1, 1, 12'h040, 2);
        repeat (4) cycle(0, 1, 0, 12'h000, 0);
        cycle(0, 1, 1, 12'h080, 0);
        repeat (4) cycle(0, 1, 0, 12'h000, 0);
`endif
        repeat (3) cycle(0, 0, 0, 12'h000, 0);
        cycle(1, 1, 0, 12'h000, 0);
        repeat (5) cycle(0, 1, 0, 12'h000, 0);

        for (int i = 0; i < 400; i++) begin
            r   = ($urandom_range(0, 96) == 0);
            rv  = !r && ($urandom_range(0, 11) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            rpc = {10'($urandom_range(0, 1023)), 2'b00};
            off = (int'($urandom_range(0, 4095)) - 2048) * 2;
            cycle(r, rdy, rv, rpc, off);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
